// File: rtl/axi_stream_wide_splitter.sv
// axi_stream_wide_splitter: splits each wide AXI-stream word into RATIO narrow beats.
// Define AXIS_SPLIT_MSB_FIRST_EN to emit the most-significant slice first.
module axi_stream_wide_splitter #(
  parameter int IN_DSIZE = 144,
  parameter int RATIO = 3,
  localparam int OUT_DSIZE = IN_DSIZE / RATIO
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 aclken,
  input  logic [IN_DSIZE-1:0]  in_tdata,
  input  logic                 in_tvalid,
  input  logic                 in_tlast,
  output logic                 in_tready,
  output logic [OUT_DSIZE-1:0] out_tdata,
  output logic                 out_tvalid,
  output logic                 out_tlast,
  input  logic                 out_tready
);
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state, state_nxt;
  logic [IN_DSIZE-1:0] hold_data, hold_data_nxt;
  logic hold_last, hold_last_nxt;
  logic [IW-1:0] idx, idx_nxt, sel;
  logic [RATIO-1:0][OUT_DSIZE-1:0] slices;
  logic last_beat, in_acc, out_acc;
  assign last_beat = idx == LAST_IDX;
  // a new word may load in the same cycle the final slice drains, so streaming has no bubble
  assign in_tready = aclken & ((state == IDLE) | (out_tready & last_beat));
  assign in_acc = in_tvalid & in_tready;
  assign out_acc = out_tvalid & out_tready & aclken;
  assign out_tvalid = state == SPLIT;
  assign out_tlast = out_tvalid & hold_last & last_beat;
  assign slices = hold_data;
`ifdef AXIS_SPLIT_MSB_FIRST_EN
  assign sel = LAST_IDX - idx;
`else
  assign sel = idx;
`endif
  assign out_tdata = slices[sel];
  always_comb begin
    state_nxt = state;
    hold_data_nxt = hold_data;
    hold_last_nxt = hold_last;
    idx_nxt = idx;
    if (in_acc) begin
      state_nxt = SPLIT;
      hold_data_nxt = in_tdata;
      hold_last_nxt = in_tlast;
      idx_nxt = '0;
    end else if (out_acc) begin
      state_nxt = last_beat ? IDLE : SPLIT;
      idx_nxt = last_beat ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      hold_data <= '0;
      hold_last <= 1'b0;
      idx <= '0;
    end else if (aclken) begin
      state <= state_nxt;
      hold_data <= hold_data_nxt;
      hold_last <= hold_last_nxt;
      idx <= idx_nxt;
    end
endmodule

// File: tb/tb_axi_stream_wide_splitter.sv
// tb_axi_stream_wide_splitter: randomized and directed checks against a beat-queue reference model.
module tb_axi_stream_wide_splitter;
  localparam int IW_D = 144;
  localparam int R = 3;
  localparam int OW = IW_D / R;
  logic aclk = 1'b0, areset, aclken, in_tvalid, in_tlast, in_tready, out_tvalid, out_tlast, out_tready;
  logic [IW_D-1:0] in_tdata;
  logic [OW-1:0] out_tdata;
  axi_stream_wide_splitter #(.IN_DSIZE(IW_D), .RATIO(R)) dut (
    .aclk(aclk), .areset(areset), .aclken(aclken),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready)
  );
  always #5 aclk = ~aclk;
  int vectors = 0, miscompares = 0;
  int pops = 0, tl_in = 0, tl_out = 0;
  logic [OW:0] q[$];
  logic s_valid, s_last, s_itr, s_in_acc, s_out_acc, prev_hold = 1'b0;
  logic [OW-1:0] s_data, prev_data;
  logic [OW-1:0] c[3];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [OW-1:0] slice_of(input logic [IW_D-1:0] w, input int k);
`ifdef AXIS_SPLIT_MSB_FIRST_EN
    return w[(R-1-k)*OW +: OW];
`else
    return w[k*OW +: OW];
`endif
  endfunction
  function automatic logic [IW_D-1:0] rnd_word();
    logic [IW_D-1:0] w;
    for (int i = 0; i < IW_D / 32 + 1; i++) w = {w[IW_D-33:0], $urandom()};
    return w;
  endfunction
  task automatic cycle();
    logic [OW:0] e;
    @(negedge aclk);
    s_valid = out_tvalid; s_data = out_tdata; s_last = out_tlast; s_itr = in_tready;
    s_in_acc = aclken & in_tvalid & in_tready;
    s_out_acc = aclken & out_tvalid & out_tready;
    if (prev_hold) check("stable", 64'(s_data), 64'(prev_data));
    if (s_in_acc) begin
      for (int k = 0; k < R; k++) q.push_back({in_tlast && k == R - 1, slice_of(in_tdata, k)});
      if (in_tlast) tl_in++;
    end
    if (s_out_acc) begin
      if (q.size() == 0) check("sb_underflow", 64'(q.size()), 64'd1);
      else begin
        e = q.pop_front();
        check("beat", 64'({s_last, s_data}), 64'(e));
        pops++;
        if (s_last) tl_out++;
      end
    end
    prev_hold = s_valid && (!aclken || !out_tready);
    prev_data = s_data;
    @(posedge aclk); #1;
  endtask
  task automatic drain(input int bound);
    int n = 0;
    in_tvalid = 1'b0;
    while (q.size() != 0 && n < bound) begin
      out_tready = 1'b1; cycle(); n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask
  task automatic send_one(input logic [IW_D-1:0] w, input logic l, input int bound);
    int n = 0;
    in_tdata = w; in_tlast = l; in_tvalid = 1'b1;
    do begin cycle(); n++; end while (!s_in_acc && n < bound);
    check("send_acc", 64'(s_in_acc), 64'd1);
    in_tvalid = 1'b0;
  endtask
  initial begin
    int first_v, last_v, nv, nacc, last_acc, sent, p0, n;
    c[0] = 48'h1111_1111_1111; c[1] = 48'h2222_2222_2222; c[2] = 48'h3333_3333_3333;
    areset = 1'b1; aclken = 1'b1; in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0; out_tready = 1'b0;
    cycle(); cycle();
    check("rst_valid", 64'(s_valid), 64'd0);
    check("rst_last", 64'(s_last), 64'd0);
    check("rst_data", 64'(s_data), 64'd0);
    check("rst_itr", 64'(s_itr), 64'd1);
    areset = 1'b0;
    // single word, LSB/MSB order from known constants
    out_tready = 1'b1;
    in_tdata = {c[2], c[1], c[0]}; in_tlast = 1'b1; in_tvalid = 1'b1;
    cycle();
    check("s1_itr", 64'(s_in_acc), 64'd1);
    in_tvalid = 1'b0;
    for (int k = 0; k < R; k++) begin
      cycle();
      check("s1_valid", 64'(s_valid), 64'd1);
`ifdef AXIS_SPLIT_MSB_FIRST_EN
      check("s1_data", 64'(s_data), 64'(c[R-1-k]));
`else
      check("s1_data", 64'(s_data), 64'(c[k]));
`endif
      check("s1_last", 64'(s_last), 64'(k == R - 1));
    end
    cycle();
    check("s1_idle", 64'(s_valid), 64'd0);
    // back-to-back streaming
    first_v = -1; last_v = -1; nv = 0; nacc = 0; last_acc = -1;
    in_tdata = rnd_word(); in_tlast = 1'b0; in_tvalid = 1'b1; out_tready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      cycle();
      if (s_valid) begin nv++; if (first_v < 0) first_v = t; last_v = t; end
      if (s_in_acc) begin
        if (last_acc >= 0) check("s2_gap", 64'(t - last_acc), 64'd3);
        last_acc = t; nacc++;
        if (nacc == 4) in_tvalid = 1'b0;
        else begin in_tdata = rnd_word(); in_tlast = nacc == 3; end
      end
    end
    check("s2_nvalid", 64'(nv), 64'd12);
    check("s2_contig", 64'(last_v - first_v + 1), 64'd12);
    check("s2_nacc", 64'(nacc), 64'd4);
    check("s2_q", 64'(q.size()), 64'd0);
    // random backpressure, 10 words
    p0 = pops; tl_in = 0; tl_out = 0; sent = 0; n = 0;
    in_tvalid = 1'b0;
    while ((sent < 10 || q.size() != 0) && n < 600) begin
      if (!in_tvalid && sent < 10 && $urandom_range(0, 1) == 1) begin
        in_tdata = rnd_word(); in_tlast = $urandom_range(0, 2) == 0; in_tvalid = 1'b1;
      end
      out_tready = $urandom_range(0, 1) == 1;
      cycle(); n++;
      if (s_in_acc) begin sent++; in_tvalid = 1'b0; end
    end
    check("s3_pops", 64'(pops - p0), 64'd30);
    check("s3_tlast", 64'(tl_out), 64'(tl_in));
    // reset mid-word after two beats
    p0 = pops; out_tready = 1'b1;
    send_one(rnd_word(), 1'b1, 10);
    n = 0;
    while (pops - p0 < 2 && n < 10) begin cycle(); n++; end
    check("s4_two", 64'(pops - p0), 64'd2);
    areset = 1'b1; #1;
    check("s4_async", 64'(out_tvalid), 64'd0);
    q.delete(); prev_hold = 1'b0;
    cycle();
    areset = 1'b0;
    p0 = pops;
    send_one(rnd_word(), 1'b0, 10);
    drain(20);
    check("s4_pops", 64'(pops - p0), 64'd3);
    // clock-enable freeze mid-word
    send_one(rnd_word(), 1'b0, 10);
    cycle();
    aclken = 1'b0; in_tdata = rnd_word(); in_tvalid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      cycle();
      check("s5_itr", 64'(s_itr), 64'd0);
      check("s5_valid", 64'(s_valid), 64'd1);
    end
    aclken = 1'b1; in_tvalid = 1'b0;
    drain(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
